ternary_adder_arbiter: RTL and testbench

Round-robin arbiter that shares one signed ternary adder between `numPorts` requesters. Each requester presents three signed operands and an operation mode over a valid/ready handshake. The block grants one requester per cycle and computes the selected sum in a two-stage pipeline. It returns the result on a single response stream, tagged with the requester index. It sits in front of the carry-save/ternary reduction datapath wherever several compressor trees contend for one adder.

---
 rtl/ternary_adder_arbiter.sv | 114 +++++++++++
 tb/tb_ternary_adder_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ternary_adder_arbiter.sv
// Round-robin arbiter sharing one signed ternary adder among numPorts requesters.
// Two-stage pipeline: grant/capture, then add into the output registers.
module ternary_adder_arbiter #(
    parameter int unsigned width    = 8,
    parameter int unsigned numPorts = 4,
    parameter int unsigned idWidth  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [numPorts-1:0]       req_valid,
    output logic [numPorts-1:0]       req_ready,
    input  logic [numPorts*width-1:0] req_data_0,
    input  logic [numPorts*width-1:0] req_data_1,
    input  logic [numPorts*width-1:0] req_data_2,
    input  logic [numPorts*2-1:0]     req_mode,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [width+1:0]          rsp_data,
    output logic [idWidth-1:0]        rsp_id
);

    logic [idWidth-1:0] last_q;
    logic [idWidth-1:0] cand;
    logic               found;
    logic               advance;
    logic               xfer;

    logic               s1_valid;
    logic [width-1:0]   s1_a;
    logic [width-1:0]   s1_b;
    logic [width-1:0]   s1_c;
    logic [1:0]         s1_mode;
    logic [idWidth-1:0] s1_id;

    logic [width+1:0]   a_ext;
    logic [width+1:0]   b_ext;
    logic [width+1:0]   c_ext;
    logic [width+1:0]   sum;

    // Search last+1, last+2, ... modulo numPorts; first valid port wins.
    always_comb begin
        int unsigned        idx;
        logic [idWidth-1:0] cidx;
        cand  = last_q;
        found = 1'b0;
        idx   = 0;
        cidx  = '0;
        for (int unsigned k = 1; k <= numPorts; k++) begin
            idx  = (32'(last_q) + k) % numPorts;
            cidx = idWidth'(idx);
            if (!found && req_valid[cidx]) begin
                found = 1'b1;
                cand  = cidx;
            end
        end
    end

    assign advance = !rsp_valid || rsp_ready;
    assign xfer    = found && advance;

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[cand] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q   <= idWidth'(numPorts - 1);
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= '0;
            s1_mode  <= '0;
            s1_id    <= '0;
        end else if (advance) begin
            s1_valid <= xfer;
            if (xfer) begin
                last_q  <= cand;
                s1_a    <= req_data_0[32'(cand)*width +: width];
                s1_b    <= req_data_1[32'(cand)*width +: width];
                s1_c    <= req_data_2[32'(cand)*width +: width];
                s1_mode <= req_mode[32'(cand)*2 +: 2];
                s1_id   <= cand;
            end
        end
    end

    // Two guard bits keep the three-operand sum exact.
    always_comb begin
        a_ext = {{2{s1_a[width-1]}}, s1_a};
        b_ext = {{2{s1_b[width-1]}}, s1_b};
        c_ext = {{2{s1_c[width-1]}}, s1_c};
        case (s1_mode)
            2'd0:    sum = a_ext + b_ext + c_ext;
            2'd1:    sum = a_ext + b_ext - c_ext;
            default: sum = a_ext - b_ext - c_ext;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else if (advance) begin
            rsp_valid <= s1_valid;
            rsp_data  <= sum;
            rsp_id    <= s1_id;
        end
    end

endmodule

// File: tb/tb_ternary_adder_arbiter.sv
// Scoreboard bench: stimulus pushes hand-computed results, a monitor pops and
// compares whenever a response is handed off.
module tb_ternary_adder_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_data_0;
    logic [31:0] req_data_1;
    logic [31:0] req_data_2;
    logic [7:0]  req_mode;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [9:0]  rsp_data;
    logic [1:0]  rsp_id;

    typedef struct {
        int id;
        int data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    ternary_adder_arbiter #(
        .width   (8),
        .numPorts(4),
        .idWidth (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data_0(req_data_0),
        .req_data_1(req_data_1),
        .req_data_2(req_data_2),
        .req_mode  (req_mode),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_port(input int p, input int a, input int b, input int c, input int m);
        req_data_0[p*8 +: 8] = 8'(a);
        req_data_1[p*8 +: 8] = 8'(b);
        req_data_2[p*8 +: 8] = 8'(c);
        req_mode[p*2 +: 2]   = 2'(m);
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic drive(input logic [3:0] vld, input logic rdy, input int grant,
                         input int data, input string name);
        exp_t e;
        req_valid = vld;
        rsp_ready = rdy;
        #3;
        chk({name, " req_ready"}, int'(req_ready), grant >= 0 ? (1 << grant) : 0);
        if (grant >= 0) begin
            e.id   = grant;
            e.data = data;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected response id", int'(rsp_id), -1);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", int'(rsp_id), e.id);
                chk("rsp_data", int'($signed(rsp_data)), e.data);
            end
        end
    end

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        rsp_ready  = 1'b1;
        req_data_0 = '0;
        req_data_1 = '0;
        req_data_2 = '0;
        req_mode   = '0;
        @(posedge clk);
        #1;
        chk("reset rsp_valid", int'(rsp_valid), 0);
        chk("reset rsp_data", int'(rsp_data), 0);
        chk("reset rsp_id", int'(rsp_id), 0);
        chk("reset req_ready", int'(req_ready), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single request and latency.
        set_port(0, 5, 3, 2, 0);
        drive(4'b0001, 1'b1, 0, 10, "single");
        chk("latency edge1 rsp_valid", int'(rsp_valid), 0);
        drive(4'b0000, 1'b1, -1, 0, "single idle");
        chk("latency edge2 rsp_valid", int'(rsp_valid), 1);
        chk("latency rsp_data", int'($signed(rsp_data)), 10);
        chk("latency rsp_id", int'(rsp_id), 0);

        // Extreme operands, lone requester granted every cycle.
        set_port(0, -128, 127, 127, 0);
        drive(4'b0001, 1'b1, 0, 126, "extreme m0");
        set_port(0, -128, 127, 127, 1);
        drive(4'b0001, 1'b1, 0, -128, "extreme m1");
        set_port(0, -128, 127, 127, 2);
        drive(4'b0001, 1'b1, 0, -382, "extreme m2");
        set_port(0, -128, 127, 127, 3);
        drive(4'b0001, 1'b1, 0, -382, "extreme m3");

        // Port p sums to 3p+6.
        for (int p = 0; p < 4; p++) set_port(p, p + 1, p + 2, p + 3, 0);
        drive(4'b1000, 1'b1, 3, 15, "align");
        for (int i = 0; i < 8; i++) drive(4'b1111, 1'b1, i % 4, 3 * (i % 4) + 6, "rr");

        // Backpressure: port 2 sits in the output register, port 3 in stage 1.
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 1'b0, -1, 0, "stall");
            chk("stall rsp_valid", int'(rsp_valid), 1);
            chk("stall rsp_id", int'(rsp_id), 2);
            chk("stall rsp_data", int'($signed(rsp_data)), 12);
        end
        drive(4'b1111, 1'b1, 0, 6, "release");
        drive(4'b1111, 1'b1, 1, 9, "release");
        for (int i = 0; i < 3; i++) drive(4'b0000, 1'b1, -1, 0, "drain");

        // Withdrawal: last=1, so port 3 wins first and port 1 then drops out.
        drive(4'b1010, 1'b1, 3, 15, "withdraw");
        drive(4'b1000, 1'b1, 3, 15, "withdraw");
        drive(4'b0110, 1'b1, 1, 9, "withdraw");
        drive(4'b0100, 1'b1, 2, 12, "withdraw");
        for (int i = 0; i < 3; i++) drive(4'b0000, 1'b1, -1, 0, "drain");

        // Reset with two results in flight (output stalled).
        drive(4'b0001, 1'b0, 0, 6, "flight");
        drive(4'b0010, 1'b0, 1, 9, "flight");
        chk("flight rsp_valid", int'(rsp_valid), 1);
        req_valid = '0;
        reset     = 1'b1;
        #1;
        chk("midreset rsp_valid", int'(rsp_valid), 0);
        chk("midreset req_ready", int'(req_ready), 0);
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(4'b0110, 1'b1, 1, 9, "post reset");
        for (int i = 0; i < 4; i++) drive(4'b0000, 1'b1, -1, 0, "drain");
        chk("scoreboard empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
